gty_bringup_seq: RTL and testbench
==================================

# gty_bringup_seq

Parametrised bring-up and recovery sequencer for `NUM_LANES` GTY transceiver channels, clocked from the 100 MHz PL free-running clock. It replaces hand-toggled reset flags with a state machine:
- drives the wizard reset and user-clock resets;
- waits on power-good, PMA-reset-done, user-clock-active and reset-done/CDR status per lane;
- enforces timeouts, with optional automatic retry.

Status is exported as slow flags for the block design.

## Interface
Parameters:
- `NUM_LANES`, 1: number of GTY channels sequenced together.
- `RESET_PULSE_CYCLES`, 16: `reset_all_out` pulse width in `pl_clk0` cycles (≥ 1).
- `STABLE_CYCLES`, 1024: consecutive cycles all power-good must be high before reset release.
- `TIMEOUT_CYCLES`, 1000000: maximum occupancy of any WAIT state (10 ms at 100 MHz).
- `MAX_RETRIES`, 3: retries before FAIL (1..255).

Ports:
- `pl_clk0` in 1: free-running 100 MHz clock; all logic in this domain.
- `pl_resetn0` in 1: synchronous, active-low reset.
- `start_in` in 1: single-cycle start / restart request.
- `gtpowergood_in` in NUM_LANES: per-lane power good (async).
- `txpmaresetdone_in`, `rxpmaresetdone_in` in NUM_LANES: per-lane PMA reset done (async).
- `userclk_tx_active_in`, `userclk_rx_active_in` in NUM_LANES: per-lane user-clock active (async).
- `reset_tx_done_in`, `reset_rx_done_in`, `rx_cdr_stable_in` in NUM_LANES: per-lane wizard status (async).
- `reset_all_out` out 1: to `gtwiz_reset_all_in`.
- `userclk_tx_reset_out`, `userclk_rx_reset_out` out NUM_LANES: user-clock helper resets.
- `link_up_out` out 1: all lanes up.
- `fail_out` out 1: sequence failed; sticky.
- `state_out` out 3: current state encoding.
- `retry_cnt_out` out 8: retries used since last start.
- `lane_fail_out` out NUM_LANES: lanes that missed the condition at the last timeout or link loss.

## Operation
- All `_in` status bits pass through 2-flop synchronisers before use. "All X" means the AND over every lane.
- States and encodings: IDLE 0, WAIT_PWRGOOD 1, ASSERT_RESET 2, WAIT_PMA 3, WAIT_USERCLK 4, WAIT_DONE 5, LINK_UP 6, FAIL 7.
- IDLE:
  - `start_in` → WAIT_PWRGOOD; `retry_cnt_out` and `lane_fail_out` are cleared.
- WAIT_PWRGOOD:
  - The stable counter increments while all power-good is high and clears on any low.
  - Reaching `STABLE_CYCLES` → ASSERT_RESET.
- ASSERT_RESET:
  - `reset_all_out` is high for exactly `RESET_PULSE_CYCLES` cycles, then → WAIT_PMA.
  - The falling edge of `reset_all_out` starts the wizard sequence.
- WAIT_PMA:
  - All TX and RX PMA-reset-done → WAIT_USERCLK.
  - User-clock resets deassert on this transition.
- WAIT_USERCLK:
  - All TX and RX user-clock active → WAIT_DONE.
- WAIT_DONE:
  - All TX done, RX done and CDR stable → LINK_UP.
- LINK_UP:
  - `link_up_out` = 1.
  - Any lane losing power-good, TX done, RX done or CDR stable is a link loss, handled like a timeout.
  - `lane_fail_out` records the offending lanes.
- Timeout:
  - The timer clears on every state entry.
  - If a WAIT state (1, 3, 4, 5) is still occupied after `TIMEOUT_CYCLES` cycles, `lane_fail_out` latches the lanes not meeting that state's exit condition. Retry handling then applies (see Configuration).
- FAIL:
  - `fail_out` = 1 and `reset_all_out` = 1.
  - Only `start_in` exits → WAIT_PWRGOOD, clearing the counters and `fail_out`.
- `start_in` is ignored in states 1–6.
- `reset_all_out` = 1 in IDLE, WAIT_PWRGOOD, ASSERT_RESET and FAIL.
- User-clock resets = 1 in states 0, 1, 2, 3 and 7.

## Timing
- Reset values:
  - State IDLE.
  - `reset_all_out` = 1; both user-clock reset vectors all ones.
  - `link_up_out` = 0, `fail_out` = 0, `state_out` = 0, `retry_cnt_out` = 0, `lane_fail_out` = 0.
- `pl_resetn0` low mid-sequence returns to reset values on the next edge, with no completion of the pulse.
- All outputs are registered and change on the same edge as the state register.
- Input-to-transition latency is 2 synchroniser cycles + 1 decision cycle = 3 cycles.
- `start_in` → `state_out` = 1 on the following edge.
- Timer width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates, never wraps.
- A timeout and the exit condition in the same cycle: the exit condition wins.
- `retry_cnt_out` saturates at `MAX_RETRIES`.

## Configuration
- `GTY_BRINGUP_RETRY_EN` defined:
  - On timeout or link loss with `retry_cnt_out` < `MAX_RETRIES`: increment the count and → ASSERT_RESET, skipping the power-good wait.
  - Otherwise → FAIL.
- Undefined:
  - Every timeout or link loss → FAIL directly.
  - `retry_cnt_out` is tied to 0 and `MAX_RETRIES` is ignored.

## Test plan
All scenarios use NUM_LANES=2, RESET_PULSE_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=100, MAX_RETRIES=2, macro defined unless noted.

- Nominal bring-up: all status inputs high, `start_in` pulse → states 1,2,3,4,5,6; `reset_all_out` high exactly 4 cycles in state 2; `link_up_out`=1; `retry_cnt_out`=0.
- Power-good glitch: lane 1 power-good drops at stable count 5 → counter restarts; ASSERT_RESET entered 8 cycles after recovery + 2-cycle sync.
- Lane 1 `rx_cdr_stable_in` held low → WAIT_DONE times out after 100 cycles, `lane_fail_out`=2'b10; 2 retries then FAIL; `retry_cnt_out`=2; `fail_out`=1; `reset_all_out`=1.
- Link loss: in LINK_UP, lane 0 `reset_tx_done_in` drops → `link_up_out`=0 within 3 cycles; state 2; `retry_cnt_out`=1; `lane_fail_out`=2'b01.
- Macro undefined, same stimulus as the `rx_cdr_stable_in` scenario → FAIL after the first timeout; `retry_cnt_out`=0.
- Mid-sequence reset: `pl_resetn0` low during state 3 → next edge state 0, all reset values; `start_in` then repeats the nominal bring-up.

Source files
------------

// File: rtl/gty_bringup_seq.sv
// Bring-up and recovery sequencer for NUM_LANES GTY channels, all in the pl_clk0 domain.
// Define GTY_BRINGUP_RETRY_EN to re-enter ASSERT_RESET on timeout or link loss instead of failing at once.
module gty_bringup_seq #(
  parameter int NUM_LANES          = 1,
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int STABLE_CYCLES      = 1024,
  parameter int TIMEOUT_CYCLES     = 1000000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                 pl_clk0,
  input  logic                 pl_resetn0,
  input  logic                 start_in,
  input  logic [NUM_LANES-1:0] gtpowergood_in,
  input  logic [NUM_LANES-1:0] txpmaresetdone_in,
  input  logic [NUM_LANES-1:0] rxpmaresetdone_in,
  input  logic [NUM_LANES-1:0] userclk_tx_active_in,
  input  logic [NUM_LANES-1:0] userclk_rx_active_in,
  input  logic [NUM_LANES-1:0] reset_tx_done_in,
  input  logic [NUM_LANES-1:0] reset_rx_done_in,
  input  logic [NUM_LANES-1:0] rx_cdr_stable_in,
  output logic                 reset_all_out,
  output logic [NUM_LANES-1:0] userclk_tx_reset_out,
  output logic [NUM_LANES-1:0] userclk_rx_reset_out,
  output logic                 link_up_out,
  output logic                 fail_out,
  output logic [2:0]           state_out,
  output logic [7:0]           retry_cnt_out,
  output logic [NUM_LANES-1:0] lane_fail_out
);

`ifdef GTY_BRINGUP_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_PWRGOOD = 3'd1,
    ST_ASSERT_RESET = 3'd2,
    ST_WAIT_PMA     = 3'd3,
    ST_WAIT_USERCLK = 3'd4,
    ST_WAIT_DONE    = 3'd5,
    ST_LINK_UP      = 3'd6,
    ST_FAIL         = 3'd7
  } state_t;

  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_MAX = (STABLE_CYCLES > RESET_PULSE_CYCLES) ? STABLE_CYCLES : RESET_PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SW      = 8 * NUM_LANES;

  localparam logic [TMR_W-1:0] TMR_SAT     = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
    return (v >= TMR_SAT) ? TMR_SAT : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1'b1;
  endfunction

  logic [SW-1:0]        status_raw, meta_q, sync_q;
  logic [NUM_LANES-1:0] pg_s, txpma_s, rxpma_s, utx_s, urx_s, txd_s, rxd_s, cdr_s;
  logic [NUM_LANES-1:0] pma_ok, uclk_ok, done_ok, link_ok, miss;
  logic                 fault, uclk_rst;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           retry_q, retry_d;
  logic [NUM_LANES-1:0] lane_fail_q, lane_fail_d;
  logic [NUM_LANES-1:0] uclk_rst_q, uclk_rst_d;
  logic                 reset_all_q, reset_all_d, link_up_q, link_up_d, fail_q, fail_d;

  // Two-flop synchronisers for every asynchronous lane status bit
  assign status_raw = {rx_cdr_stable_in, reset_rx_done_in, reset_tx_done_in, userclk_rx_active_in,
                       userclk_tx_active_in, rxpmaresetdone_in, txpmaresetdone_in, gtpowergood_in};

  always_ff @(posedge pl_clk0) begin
    meta_q <= status_raw;
    sync_q <= meta_q;
  end

  assign pg_s    = sync_q[0*NUM_LANES +: NUM_LANES];
  assign txpma_s = sync_q[1*NUM_LANES +: NUM_LANES];
  assign rxpma_s = sync_q[2*NUM_LANES +: NUM_LANES];
  assign utx_s   = sync_q[3*NUM_LANES +: NUM_LANES];
  assign urx_s   = sync_q[4*NUM_LANES +: NUM_LANES];
  assign txd_s   = sync_q[5*NUM_LANES +: NUM_LANES];
  assign rxd_s   = sync_q[6*NUM_LANES +: NUM_LANES];
  assign cdr_s   = sync_q[7*NUM_LANES +: NUM_LANES];

  assign pma_ok  = txpma_s & rxpma_s;
  assign uclk_ok = utx_s & urx_s;
  assign done_ok = txd_s & rxd_s & cdr_s;
  assign link_ok = pg_s & done_ok;

  // Decision stage: exit conditions are tested before the timeout, so they win a tie
  always_comb begin
    state_d     = state_q;
    timer_d     = tmr_inc(timer_q);
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lane_fail_d = lane_fail_q;
    fault       = 1'b0;
    miss        = '0;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start_in) begin
          state_d     = ST_WAIT_PWRGOOD;
          retry_d     = '0;
          lane_fail_d = '0;
        end
      end
      ST_WAIT_PWRGOOD: begin
        if (&pg_s && cnt_q >= STABLE_LAST) begin
          state_d = ST_ASSERT_RESET;
        end else if (timer_q >= TMR_LAST) begin
          fault = 1'b1;
          miss  = ~pg_s;
        end else begin
          cnt_d = (&pg_s) ? cnt_inc(cnt_q) : '0;
        end
      end
      ST_ASSERT_RESET: begin
        cnt_d = cnt_inc(cnt_q);
        if (cnt_q >= PULSE_LAST) state_d = ST_WAIT_PMA;
      end
      ST_WAIT_PMA: begin
        if (&pma_ok) state_d = ST_WAIT_USERCLK;
        else if (timer_q >= TMR_LAST) begin
          fault = 1'b1;
          miss  = ~pma_ok;
        end
      end
      ST_WAIT_USERCLK: begin
        if (&uclk_ok) state_d = ST_WAIT_DONE;
        else if (timer_q >= TMR_LAST) begin
          fault = 1'b1;
          miss  = ~uclk_ok;
        end
      end
      ST_WAIT_DONE: begin
        if (&done_ok) state_d = ST_LINK_UP;
        else if (timer_q >= TMR_LAST) begin
          fault = 1'b1;
          miss  = ~done_ok;
        end
      end
      ST_LINK_UP: begin
        if (!(&link_ok)) begin
          fault = 1'b1;
          miss  = ~link_ok;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fault) begin
      lane_fail_d = miss;
      if (RETRY_EN && retry_q < RETRY_MAX) begin
        retry_d = retry_q + 8'd1;
        state_d = ST_ASSERT_RESET;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (state_d != state_q) begin
      timer_d = '0;
      cnt_d   = '0;
    end

    reset_all_d = state_d inside {ST_IDLE, ST_WAIT_PWRGOOD, ST_ASSERT_RESET, ST_FAIL};
    uclk_rst    = state_d inside {ST_IDLE, ST_WAIT_PWRGOOD, ST_ASSERT_RESET, ST_WAIT_PMA, ST_FAIL};
    uclk_rst_d  = {NUM_LANES{uclk_rst}};
    link_up_d   = (state_d == ST_LINK_UP);
    fail_d      = (state_d == ST_FAIL);
  end

  // Registered state and outputs, all updated on the same edge
  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn0) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      lane_fail_q <= '0;
      uclk_rst_q  <= '1;
      reset_all_q <= 1'b1;
      link_up_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lane_fail_q <= lane_fail_d;
      uclk_rst_q  <= uclk_rst_d;
      reset_all_q <= reset_all_d;
      link_up_q   <= link_up_d;
      fail_q      <= fail_d;
    end
  end

  assign reset_all_out        = reset_all_q;
  assign userclk_tx_reset_out = uclk_rst_q;
  assign userclk_rx_reset_out = uclk_rst_q;
  assign link_up_out          = link_up_q;
  assign fail_out             = fail_q;
  assign state_out            = state_q;
  assign retry_cnt_out        = retry_q;
  assign lane_fail_out        = lane_fail_q;

endmodule

// File: tb/tb_gty_bringup_seq.sv
// Self-checking bench for gty_bringup_seq: scenario tasks with randomized timing and an
// edge-count reference model derived from the sequencing rules.
module tb_gty_bringup_seq;
  localparam int NL = 2;
  localparam int RP = 4;
  localparam int SC = 8;
  localparam int TO = 100;
  localparam int MR = 2;
`ifdef GTY_BRINGUP_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [NL-1:0] pg, txpma, rxpma, utx, urx, txd, rxd, cdr;
  logic          reset_all, link_up, fail;
  logic [NL-1:0] utx_rst, urx_rst, lane_fail;
  logic [2:0]    st;
  logic [7:0]    retry;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  gty_bringup_seq #(
    .NUM_LANES(NL), .RESET_PULSE_CYCLES(RP), .STABLE_CYCLES(SC),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .pl_clk0(clk), .pl_resetn0(rstn), .start_in(start),
    .gtpowergood_in(pg), .txpmaresetdone_in(txpma), .rxpmaresetdone_in(rxpma),
    .userclk_tx_active_in(utx), .userclk_rx_active_in(urx),
    .reset_tx_done_in(txd), .reset_rx_done_in(rxd), .rx_cdr_stable_in(cdr),
    .reset_all_out(reset_all), .userclk_tx_reset_out(utx_rst), .userclk_rx_reset_out(urx_rst),
    .link_up_out(link_up), .fail_out(fail), .state_out(st),
    .retry_cnt_out(retry), .lane_fail_out(lane_fail)
  );

  function automatic bit ra_exp(input int s);
    return (s <= 2) || (s == 7);
  endfunction

  function automatic bit urst_exp(input int s);
    return (s <= 3) || (s == 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_status(input logic [NL-1:0] v);
    pg = v; txpma = v; rxpma = v; utx = v; urx = v; txd = v; rxd = v; cdr = v;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    set_status('1);
    rstn = 1'b0;
    tick();
    tick();
    total++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st); end
    total++; if (reset_all !== 1'b1) begin bad++; $display("FAIL reset_all: got %0b want 1", reset_all); end
    total++; if (utx_rst !== 2'b11 || urx_rst !== 2'b11) begin bad++; $display("FAIL reset_uclk: got %b/%b want 11/11", utx_rst, urx_rst); end
    total++; if (link_up !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL reset_flags: got link=%0b fail=%0b want 0/0", link_up, fail); end
    total++; if (retry !== 8'd0 || lane_fail !== 2'b00) begin bad++; $display("FAIL reset_counts: got retry=%0d lane=%b want 0/00", retry, lane_fail); end
    rstn = 1'b1;
    repeat (5) tick();
    total++; if (st !== 3'd0) begin bad++; $display("FAIL idle_hold: got %0d want 0", st); end
  endtask

  task automatic test_nominal(input bit fresh);
    int q[$];
    if (fresh) begin
      set_status('1);
      do_reset();
    end
    q = {};
    repeat (SC) q.push_back(1);
    repeat (RP) q.push_back(2);
    q.push_back(3); q.push_back(4); q.push_back(5);
    repeat (4) q.push_back(6);
    pulse_start();
    for (int k = 0; k < q.size(); k++) begin
      total++; if (st !== 3'(q[k])) begin bad++; $display("FAIL nominal_state k=%0d: got %0d want %0d", k, st, q[k]); end
      total++; if (reset_all !== ra_exp(q[k])) begin bad++; $display("FAIL nominal_reset_all k=%0d: got %0b want %0b", k, reset_all, ra_exp(q[k])); end
      total++; if (utx_rst !== {NL{urst_exp(q[k])}} || urx_rst !== {NL{urst_exp(q[k])}}) begin bad++; $display("FAIL nominal_uclk k=%0d: got %b/%b want %0b", k, utx_rst, urx_rst, urst_exp(q[k])); end
      total++; if (link_up !== (q[k] == 6)) begin bad++; $display("FAIL nominal_link k=%0d: got %0b want %0b", k, link_up, q[k] == 6); end
      start = (k == 9);
      tick();
    end
    start = 1'b0;
    total++; if (retry !== 8'd0 || fail !== 1'b0 || lane_fail !== 2'b00) begin bad++; $display("FAIL nominal_final: got retry=%0d fail=%0b lane=%b want 0/0/00", retry, fail, lane_fail); end
  endtask

  task automatic test_pg_glitch();
    int q[$];
    int len;
    len = $urandom_range(1, 20);
    set_status('1);
    do_reset();
    q = {};
    repeat (15 + len) q.push_back(1);
    q.push_back(2);
    pulse_start();
    for (int k = 0; k < q.size(); k++) begin
      total++; if (st !== 3'(q[k])) begin bad++; $display("FAIL glitch_state len=%0d k=%0d: got %0d want %0d", len, k, st, q[k]); end
      if (k == 5) pg[1] = 1'b0;
      if (k == 5 + len) pg[1] = 1'b1;
      if (k < q.size() - 1) tick();
    end
  endtask

  task automatic test_timeout_cdr();
    int q[$];
    int r[$];
    int att;
    set_status('1);
    cdr[1] = 1'b0;
    do_reset();
    att = RETRY_EN ? MR + 1 : 1;
    q = {}; r = {};
    repeat (SC) begin q.push_back(1); r.push_back(0); end
    for (int a = 0; a < att; a++) begin
      repeat (RP) begin q.push_back(2); r.push_back(a); end
      q.push_back(3); r.push_back(a);
      q.push_back(4); r.push_back(a);
      repeat (TO) begin q.push_back(5); r.push_back(a); end
    end
    repeat (3) begin q.push_back(7); r.push_back(att - 1); end
    pulse_start();
    for (int k = 0; k < q.size(); k++) begin
      total++; if (st !== 3'(q[k])) begin bad++; $display("FAIL cdr_state k=%0d: got %0d want %0d", k, st, q[k]); end
      total++; if (retry !== 8'(r[k])) begin bad++; $display("FAIL cdr_retry k=%0d: got %0d want %0d", k, retry, r[k]); end
      if (k < q.size() - 1) tick();
    end
    total++; if (lane_fail !== 2'b10) begin bad++; $display("FAIL cdr_lane_fail: got %b want 10", lane_fail); end
    total++; if (fail !== 1'b1 || reset_all !== 1'b1 || link_up !== 1'b0) begin bad++; $display("FAIL cdr_fail_flags: got fail=%0b rst=%0b link=%0b want 1/1/0", fail, reset_all, link_up); end
    cdr = '1;
    repeat (4) tick();
    total++; if (st !== 3'd7 || fail !== 1'b1) begin bad++; $display("FAIL fail_sticky: got st=%0d fail=%0b want 7/1", st, fail); end
    pulse_start();
    total++; if (st !== 3'd1 || fail !== 1'b0) begin bad++; $display("FAIL fail_restart: got st=%0d fail=%0b want 1/0", st, fail); end
    total++; if (retry !== 8'd0 || lane_fail !== 2'b00) begin bad++; $display("FAIL fail_restart_counts: got retry=%0d lane=%b want 0/00", retry, lane_fail); end
  endtask

  task automatic test_link_loss(input int it);
    int sig;
    logic [NL-1:0] m;
    if (it == 0) begin
      sig = 1;
      m = 2'b01;
    end else begin
      sig = $urandom_range(0, 3);
      m = NL'($urandom_range(1, 3));
    end
    set_status('1);
    do_reset();
    pulse_start();
    repeat (15) tick();
    total++; if (st !== 3'd6 || link_up !== 1'b1) begin bad++; $display("FAIL loss_up: got st=%0d link=%0b want 6/1", st, link_up); end
    repeat (4) tick();
    case (sig)
      0: pg = pg & ~m;
      1: txd = txd & ~m;
      2: rxd = rxd & ~m;
      default: cdr = cdr & ~m;
    endcase
    tick();
    tick();
    total++; if (link_up !== 1'b1) begin bad++; $display("FAIL loss_early sig=%0d: got %0b want 1", sig, link_up); end
    tick();
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL loss_link sig=%0d: got %0b want 0", sig, link_up); end
    total++; if (st !== (RETRY_EN ? 3'd2 : 3'd7)) begin bad++; $display("FAIL loss_state sig=%0d: got %0d want %0d", sig, st, RETRY_EN ? 2 : 7); end
    total++; if (retry !== (RETRY_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL loss_retry: got %0d want %0d", retry, RETRY_EN ? 1 : 0); end
    total++; if (lane_fail !== m || reset_all !== 1'b1) begin bad++; $display("FAIL loss_lanes: got lane=%b rst=%0b want %b/1", lane_fail, reset_all, m); end
  endtask

  task automatic test_random_pma(input int it);
    int d[4];
    int dmax, endk, e, j, tgt;
    bit ok;
    logic [NL-1:0] miss_exp;
    for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 110);
    if (it < 2) begin
      tgt = TO - 3 + it;
      for (int i = 0; i < 4; i++) if (d[i] > tgt) d[i] = tgt;
      j = $urandom_range(0, 3);
      d[j] = tgt;
    end
    dmax = 0;
    for (int i = 0; i < 4; i++) if (d[i] > dmax) dmax = d[i];
    ok = (dmax + 3 <= TO);
    for (int l = 0; l < NL; l++) miss_exp[l] = (d[l] > TO - 3) || (d[l + 2] > TO - 3);
    set_status('1);
    txpma = '0;
    rxpma = '0;
    do_reset();
    pulse_start();
    endk = ok ? 18 + dmax : 12 + TO;
    for (int k = 0; k <= endk; k++) begin
      if (k < SC) e = 1;
      else if (k < SC + RP) e = 2;
      else if (ok) e = (k < 15 + dmax) ? 3 : (k == 15 + dmax) ? 4 : (k == 16 + dmax) ? 5 : 6;
      else e = (k < 12 + TO) ? 3 : (RETRY_EN ? 2 : 7);
      total++; if (st !== 3'(e)) begin bad++; $display("FAIL pma_state it=%0d dmax=%0d k=%0d: got %0d want %0d", it, dmax, k, st, e); end
      for (int l = 0; l < NL; l++) begin
        if (k == 12 + d[l]) txpma[l] = 1'b1;
        if (k == 12 + d[l + 2]) rxpma[l] = 1'b1;
      end
      if (k < endk) tick();
    end
    if (ok) begin
      total++; if (link_up !== 1'b1 || lane_fail !== 2'b00) begin bad++; $display("FAIL pma_up it=%0d: got link=%0b lane=%b want 1/00", it, link_up, lane_fail); end
    end else begin
      total++; if (lane_fail !== miss_exp) begin bad++; $display("FAIL pma_lanes it=%0d: got %b want %b", it, lane_fail, miss_exp); end
      total++; if (retry !== (RETRY_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL pma_retry it=%0d: got %0d want %0d", it, retry, RETRY_EN ? 1 : 0); end
    end
  endtask

  task automatic test_mid_reset();
    set_status('1);
    txpma = '0;
    do_reset();
    pulse_start();
    repeat (14) tick();
    total++; if (st !== 3'd3) begin bad++; $display("FAIL mid_pre_state: got %0d want 3", st); end
    rstn = 1'b0;
    tick();
    total++; if (st !== 3'd0 || reset_all !== 1'b1) begin bad++; $display("FAIL mid_reset_state: got st=%0d rst=%0b want 0/1", st, reset_all); end
    total++; if (utx_rst !== 2'b11 || urx_rst !== 2'b11) begin bad++; $display("FAIL mid_reset_uclk: got %b/%b want 11/11", utx_rst, urx_rst); end
    total++; if (link_up !== 1'b0 || fail !== 1'b0 || retry !== 8'd0 || lane_fail !== 2'b00) begin bad++; $display("FAIL mid_reset_flags: got link=%0b fail=%0b retry=%0d lane=%b want 0/0/0/00", link_up, fail, retry, lane_fail); end
    rstn = 1'b1;
    txpma = '1;
    repeat (3) tick();
    test_nominal(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    set_status('1);
    test_reset();
    test_nominal(1'b1);
    repeat (2) test_pg_glitch();
    test_timeout_cdr();
    for (int i = 0; i < 3; i++) test_link_loss(i);
    for (int i = 0; i < 10; i++) test_random_pma(i);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
